mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Responder end of the controller's memory strobe interface.
- Owns the program counter (PC), the 16-bit memory address register (MREG) and the byte RAM array.
- Serves ram_read_pc / ram_read_mreg / ram_write / cnt_* strobes onto and off the shared data bus.
- After reset, runs a boot-load FSM that fills RAM from a valid/ready byte stream, then releases the CPU via cpu_run.

Parameters:
DEPTH_LOG2, 10, RAM holds 2**DEPTH_LOG2 bytes; 16-bit addresses use the low DEPTH_LOG2 bits (aliasing).
ADDR_W, 16, width of PC and MREG.

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
bus_in  in  8  resolved data bus (value loaded into MREG / written to RAM)
bus_out  out  8  data this block drives onto the bus
bus_out_en  out  1  bus_out is valid this cycle
ram_read_pc  in  1  drive mem[PC] onto bus
ram_read_mreg  in  1  drive mem[MREG] onto bus
ram_write  in  1  mem[MREG] <= bus_in
mreg_h_load  in  1  MREG[15:8] <= bus_in
mreg_l_load  in  1  MREG[7:0] <= bus_in
cnt_en  in  1  PC increment
cnt_wr  in  1  PC <= MREG
cnt_l_out  in  1  drive PC[7:0] onto bus
cnt_h_out  in  1  drive PC[15:8] onto bus
halt  in  1  controller halt request
ld_valid  in  1  loader byte valid
ld_data  in  8  loader byte
ld_last  in  1  final loader byte
ld_ready  out  1  loader byte accepted when valid&ready
cpu_run  out  1  1 = controller may execute (top holds controller reset while 0)
pc  out  16  current PC
mreg  out  16  current MREG
err_conflict  out  1  sticky bus-conflict flag

Behaviour:
- Reset (async, reset_n=0):
  - State S_LOAD; PC=0, MREG=0, load_ptr=0, err_conflict=0.
  - Outputs: bus_out=0, bus_out_en=0, cpu_run=0, ld_ready=0.
  - RAM array is not cleared.
- FSM states: S_LOAD, S_RUN, S_HALT.
- S_LOAD:
  - ld_ready=1. On ld_valid&ld_ready: mem[load_ptr] <= ld_data, load_ptr++.
  - Transition to S_RUN on an accepted byte with ld_last=1, or when the accepted byte lands at load_ptr = DEPTH-1 (full).
  - All CPU strobes are ignored.
  - PC and MREG are forced to 0 on the transition.
- S_RUN:
  - cpu_run=1, ld_ready=0, ld_valid ignored.
  - halt=1 moves to S_HALT next edge.
- S_HALT:
  - cpu_run=0, all strobes ignored, PC/MREG frozen.
  - Exit only via reset.
- Read path in S_RUN is combinational, same cycle as the strobe (the controller loads the destination register on that edge):
  - ram_read_pc -> bus_out=mem[PC]
  - ram_read_mreg -> bus_out=mem[MREG]
  - cnt_l_out -> PC[7:0]
  - cnt_h_out -> PC[15:8]
  - Any of these asserts bus_out_en=1; otherwise bus_out=0, bus_out_en=0.
- Writes/updates at the rising edge in S_RUN:
  - ram_write: mem[MREG] <= bus_in.
  - mreg_h_load / mreg_l_load: update their byte independently; both may assert together.
- PC update:
  - cnt_wr has priority over cnt_en: PC <= MREG, increment dropped.
  - cnt_en alone: PC <= PC+1, modulo 2**16 (16'hFFFF -> 0).
  - A read of mem[PC] in the same cycle as cnt_en uses the pre-increment PC.
- MREG load and ram_read_mreg in the same cycle: the read uses the old MREG.
- Conflict condition: more than one of {ram_read_pc, ram_read_mreg, cnt_l_out, cnt_h_out}, or ram_write with any read source. On conflict:
  - bus_out=0, bus_out_en=0, RAM write suppressed.
  - err_conflict is set and stays set until reset.
  - PC/MREG updates still occur.
- Reset mid-load or mid-run: restart in S_LOAD at load_ptr=0; previously loaded bytes remain in RAM.

Decomposition:
- Package tinymcu_mem_pkg holds:
  - state enum {S_LOAD, S_RUN, S_HALT}
  - DEPTH_LOG2 default
  - address-aliasing helper function (low DEPTH_LOG2 bits)
- Sub-module mem_array:
  - 2**DEPTH_LOG2 x 8 storage, one async read port and one sync write port.
  - The write port is muxed in mem_responder: loader in S_LOAD, CPU in S_RUN.

Test Plan:
- Load bytes 0x11,0x22,0x33 (last on 0x33) -> mem[0..2]=11,22,33; cpu_run=1 the cycle after; PC=0, ld_ready=0.
- S_RUN, ram_read_pc+cnt_en for two cycles -> bus_out 0x11 then 0x22, bus_out_en=1; PC=2 afterwards.
- mreg_h_load with bus_in=0x00, mreg_l_load with 0x02, ram_write with bus_in=0x5A, then ram_read_mreg -> bus_out=0x5A; MREG=0x0002.
- MREG=0x0002, cnt_wr=1 and cnt_en=1 together -> PC=0x0002. Force PC=0xFFFF via MREG+cnt_wr, then cnt_en -> PC=0x0000. cnt_h_out -> bus_out=0x00.
- ram_read_pc=1 and ram_read_mreg=1 together -> bus_out_en=0, err_conflict=1 and still 1 ten cycles later. ram_write+ram_read_pc -> mem[MREG] unchanged.
- halt=1 in S_RUN -> cpu_run=0 next cycle; a subsequent cnt_en leaves PC unchanged. Drop reset_n after 2 of 4 load bytes -> S_LOAD, load_ptr=0, ld_ready=1 after release.

Source files
------------

// File: rtl/tinymcu_mem_pkg.sv
// Shared types and helpers for the memory responder: FSM states, default RAM depth
// and the address-aliasing helper that maps 16-bit addresses onto the byte array.
package tinymcu_mem_pkg;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam int DEPTH_LOG2_DEF = 10;

    // Keeps only the low depth_log2 bits, so addresses past the array alias back onto it.
    function automatic logic [15:0] mem_alias(input logic [15:0] addr, input int unsigned depth_log2);
        logic [15:0] mask;
        mask = (16'h0001 << depth_log2) - 16'h0001;
        return addr & mask;
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Byte RAM with one asynchronous read port and one synchronous write port.
// Contents are deliberately not reset so a reload can rely on earlier bytes surviving.
module mem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [7:0]            wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [7:0]            rdata
);

    logic [7:0] mem_r [0:(1<<DEPTH_LOG2)-1];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/mem_responder.sv
// Responder side of the controller memory strobe interface: owns PC, MREG and the RAM,
// boot-loads RAM from a byte stream, then serves CPU strobes until halted.
module mem_responder
    import tinymcu_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        bus_in,
    output logic [7:0]        bus_out,
    output logic              bus_out_en,
    input  logic              ram_read_pc,
    input  logic              ram_read_mreg,
    input  logic              ram_write,
    input  logic              mreg_h_load,
    input  logic              mreg_l_load,
    input  logic              cnt_en,
    input  logic              cnt_wr,
    input  logic              cnt_l_out,
    input  logic              cnt_h_out,
    input  logic              halt,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              cpu_run,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] mreg,
    output logic              err_conflict
);

    localparam logic [DEPTH_LOG2-1:0] LAST_PTR = {DEPTH_LOG2{1'b1}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0]     PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t                state_r;
    state_t                next_state_s;
    logic [ADDR_W-1:0]     pc_r;
    logic [ADDR_W-1:0]     mreg_r;
    logic [DEPTH_LOG2-1:0] load_ptr_r;
    logic                  err_r;
    logic                  cpu_run_r;
    logic                  ld_ready_r;

    logic                  run_s;
    logic                  accept_s;
    logic                  load_done_s;
    logic                  conflict_s;
    logic [2:0]            rd_cnt_s;
    logic                  mem_we_s;
    logic [DEPTH_LOG2-1:0] mem_waddr_s;
    logic [DEPTH_LOG2-1:0] mem_raddr_s;
    logic [7:0]            mem_wdata_s;
    logic [7:0]            mem_rdata_s;

    assign run_s       = (state_r == S_RUN);
    assign accept_s    = (state_r == S_LOAD) && ld_valid && ld_ready_r;
    assign load_done_s = accept_s && (ld_last || (load_ptr_r == LAST_PTR));
    assign rd_cnt_s    = {2'b00, ram_read_pc} + {2'b00, ram_read_mreg}
                       + {2'b00, cnt_l_out} + {2'b00, cnt_h_out};
    assign conflict_s  = run_s && ((rd_cnt_s > 3'd1) || (ram_write && (rd_cnt_s != 3'd0)));
    assign mem_raddr_s = ram_read_mreg ? DEPTH_LOG2'(mem_alias(mreg_r, DEPTH_LOG2))
                                       : DEPTH_LOG2'(mem_alias(pc_r, DEPTH_LOG2));

    // Next-state decode; S_HALT is only left through reset
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_LOAD: begin
                if (load_done_s) next_state_s = S_RUN;
                else             next_state_s = S_LOAD;
            end
            S_RUN: begin
                if (halt) next_state_s = S_HALT;
                else      next_state_s = S_RUN;
            end
            S_HALT:  next_state_s = S_HALT;
            default: next_state_s = S_LOAD;
        endcase
    end

    // RAM write port mux: loader owns it while loading, CPU while running
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = load_ptr_r;
        mem_wdata_s = ld_data;
        case (state_r)
            S_LOAD: mem_we_s = accept_s;
            S_RUN: begin
                mem_we_s    = ram_write && !conflict_s;
                mem_waddr_s = DEPTH_LOG2'(mem_alias(mreg_r, DEPTH_LOG2));
                mem_wdata_s = bus_in;
            end
            default: mem_we_s = 1'b0;
        endcase
    end

    // Same-cycle bus drive; the controller captures it on the coming edge
    always_comb begin
        bus_out    = 8'h00;
        bus_out_en = 1'b0;
        if (run_s && !conflict_s) begin
            if (ram_read_pc || ram_read_mreg) begin
                bus_out    = mem_rdata_s;
                bus_out_en = 1'b1;
            end else if (cnt_l_out) begin
                bus_out    = pc_r[7:0];
                bus_out_en = 1'b1;
            end else if (cnt_h_out) begin
                bus_out    = pc_r[15:8];
                bus_out_en = 1'b1;
            end else begin
                bus_out    = 8'h00;
                bus_out_en = 1'b0;
            end
        end else begin
            bus_out    = 8'h00;
            bus_out_en = 1'b0;
        end
    end

    // State, PC/MREG, loader pointer, sticky conflict flag and registered handshakes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= S_LOAD;
            pc_r       <= {ADDR_W{1'b0}};
            mreg_r     <= {ADDR_W{1'b0}};
            load_ptr_r <= {DEPTH_LOG2{1'b0}};
            err_r      <= 1'b0;
            cpu_run_r  <= 1'b0;
            ld_ready_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            cpu_run_r  <= (next_state_s == S_RUN);
            ld_ready_r <= (next_state_s == S_LOAD);
            case (state_r)
                S_LOAD: begin
                    if (accept_s) load_ptr_r <= load_ptr_r + PTR_ONE;
                    if (load_done_s) begin
                        pc_r   <= {ADDR_W{1'b0}};
                        mreg_r <= {ADDR_W{1'b0}};
                    end
                end
                S_RUN: begin
                    // Conflicts only gate the bus and the RAM write, never PC/MREG
                    if (cnt_wr)      pc_r <= mreg_r;
                    else if (cnt_en) pc_r <= pc_r + PC_ONE;
                    if (mreg_h_load) mreg_r[ADDR_W-1:8] <= bus_in;
                    if (mreg_l_load) mreg_r[7:0] <= bus_in;
                    if (conflict_s)  err_r <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    mem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem_array (
        .clk  (clk),
        .we   (mem_we_s),
        .waddr(mem_waddr_s),
        .wdata(mem_wdata_s),
        .raddr(mem_raddr_s),
        .rdata(mem_rdata_s)
    );

    assign pc           = pc_r;
    assign mreg         = mreg_r;
    assign err_conflict = err_r;
    assign cpu_run      = cpu_run_r;
    assign ld_ready     = ld_ready_r;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: expected bus values are queued as strobes are
// driven and compared when the responder drives the bus on that cycle.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  bus_in;
    logic [7:0]  bus_out;
    logic        bus_out_en;
    logic        ram_read_pc, ram_read_mreg, ram_write;
    logic        mreg_h_load, mreg_l_load;
    logic        cnt_en, cnt_wr, cnt_l_out, cnt_h_out;
    logic        halt;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        cpu_run;
    logic [15:0] pc;
    logic [15:0] mreg;
    logic        err_conflict;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       en;
        logic [7:0] data;
    } bus_exp_t;

    bus_exp_t exp_q[$];

    always #5 clk = ~clk;

    mem_responder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus_in       (bus_in),
        .bus_out      (bus_out),
        .bus_out_en   (bus_out_en),
        .ram_read_pc  (ram_read_pc),
        .ram_read_mreg(ram_read_mreg),
        .ram_write    (ram_write),
        .mreg_h_load  (mreg_h_load),
        .mreg_l_load  (mreg_l_load),
        .cnt_en       (cnt_en),
        .cnt_wr       (cnt_wr),
        .cnt_l_out    (cnt_l_out),
        .cnt_h_out    (cnt_h_out),
        .halt         (halt),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .ld_ready     (ld_ready),
        .cpu_run      (cpu_run),
        .pc           (pc),
        .mreg         (mreg),
        .err_conflict (err_conflict)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_strobes();
        ram_read_pc   = 1'b0;
        ram_read_mreg = 1'b0;
        ram_write     = 1'b0;
        mreg_h_load   = 1'b0;
        mreg_l_load   = 1'b0;
        cnt_en        = 1'b0;
        cnt_wr        = 1'b0;
        cnt_l_out     = 1'b0;
        cnt_h_out     = 1'b0;
        halt          = 1'b0;
        bus_in        = 8'h00;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Strobes are already driven; queue the expectation, check mid-cycle, then release
    task automatic bus_cycle(input string tag, input logic en, input logic [7:0] data);
        bus_exp_t e;
        e.en   = en;
        e.data = en ? data : 8'h00;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        check_val({tag, "_en"}, {31'd0, bus_out_en}, {31'd0, e.en});
        check_val({tag, "_data"}, {24'd0, bus_out}, {24'd0, e.data});
        sync();
        clear_strobes();
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        int waited;
        waited   = 0;
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        @(negedge clk);
        while (!ld_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_val("ld_ready_wait", {31'd0, ld_ready}, 32'd1);
        sync();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(negedge clk);
        check_val("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
        check_val("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        check_val("rst_pc", {16'd0, pc}, 32'd0);
        check_val("rst_err", {31'd0, err_conflict}, 32'd0);
        sync();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        reset_n  = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        ld_last  = 1'b0;
        clear_strobes();
        repeat (2) @(negedge clk);
        check_val("reset_pc", {16'd0, pc}, 32'd0);
        check_val("reset_mreg", {16'd0, mreg}, 32'd0);
        check_val("reset_cpu_run", {31'd0, cpu_run}, 32'd0);
        check_val("reset_ld_ready", {31'd0, ld_ready}, 32'd0);
        check_val("reset_bus_en", {31'd0, bus_out_en}, 32'd0);
        check_val("reset_bus", {24'd0, bus_out}, 32'd0);
        check_val("reset_err", {31'd0, err_conflict}, 32'd0);
        sync();
        reset_n = 1'b1;

        load_byte(8'h11, 1'b0);
        load_byte(8'h22, 1'b0);
        load_byte(8'h33, 1'b1);
        @(negedge clk);
        check_val("run_after_load", {31'd0, cpu_run}, 32'd1);
        check_val("ready_after_load", {31'd0, ld_ready}, 32'd0);
        check_val("pc_after_load", {16'd0, pc}, 32'd0);
        sync();

        ram_read_pc = 1'b1; cnt_en = 1'b1; bus_cycle("rd_pc0", 1'b1, 8'h11);
        ram_read_pc = 1'b1; cnt_en = 1'b1; bus_cycle("rd_pc1", 1'b1, 8'h22);
        @(negedge clk); check_val("pc_two", {16'd0, pc}, 32'h2); sync();

        mreg_h_load = 1'b1; bus_in = 8'h00; bus_cycle("mreg_h", 1'b0, 8'h00);
        mreg_l_load = 1'b1; bus_in = 8'h02; bus_cycle("mreg_l", 1'b0, 8'h00);
        ram_write = 1'b1; bus_in = 8'h5A;   bus_cycle("ram_wr", 1'b0, 8'h00);
        ram_read_mreg = 1'b1;               bus_cycle("rd_mreg", 1'b1, 8'h5A);
        @(negedge clk); check_val("mreg_0002", {16'd0, mreg}, 32'h0002); sync();

        cnt_en = 1'b1;                bus_cycle("inc", 1'b0, 8'h00);
        cnt_wr = 1'b1; cnt_en = 1'b1; bus_cycle("wr_pri", 1'b0, 8'h00);
        @(negedge clk); check_val("cnt_wr_priority", {16'd0, pc}, 32'h0002); sync();

        mreg_h_load = 1'b1; mreg_l_load = 1'b1; bus_in = 8'hFF; bus_cycle("mreg_both", 1'b0, 8'h00);
        cnt_wr = 1'b1; bus_cycle("pc_ffff", 1'b0, 8'h00);
        @(negedge clk);
        check_val("mreg_ffff", {16'd0, mreg}, 32'hFFFF);
        check_val("pc_ffff", {16'd0, pc}, 32'hFFFF);
        sync();
        cnt_h_out = 1'b1; bus_cycle("pc_h_ff", 1'b1, 8'hFF);
        cnt_l_out = 1'b1; bus_cycle("pc_l_ff", 1'b1, 8'hFF);
        cnt_en = 1'b1;    bus_cycle("pc_wrap", 1'b0, 8'h00);
        @(negedge clk); check_val("pc_wrap", {16'd0, pc}, 32'h0000); sync();
        cnt_h_out = 1'b1; bus_cycle("pc_h_00", 1'b1, 8'h00);

        mreg_h_load = 1'b1; bus_in = 8'h04; bus_cycle("mreg_h04", 1'b0, 8'h00);
        mreg_l_load = 1'b1; bus_in = 8'h02; bus_cycle("mreg_l02", 1'b0, 8'h00);
        ram_read_mreg = 1'b1; bus_cycle("rd_alias", 1'b1, 8'h5A);
        ram_read_mreg = 1'b1; mreg_l_load = 1'b1; bus_in = 8'h01; bus_cycle("rd_old_mreg", 1'b1, 8'h5A);
        ram_read_mreg = 1'b1; bus_cycle("rd_new_mreg", 1'b1, 8'h22);
        @(negedge clk); check_val("no_err_yet", {31'd0, err_conflict}, 32'd0); sync();

        ram_write = 1'b1; ram_read_pc = 1'b1; bus_in = 8'hEE; bus_cycle("wr_conflict", 1'b0, 8'h00);
        @(negedge clk); check_val("err_set_wr", {31'd0, err_conflict}, 32'd1); sync();
        ram_read_mreg = 1'b1; bus_cycle("wr_suppressed", 1'b1, 8'h22);
        ram_read_pc = 1'b1;   bus_cycle("rd_pc_mem0", 1'b1, 8'h11);
        ram_read_pc = 1'b1; ram_read_mreg = 1'b1; cnt_en = 1'b1; bus_cycle("rd_conflict", 1'b0, 8'h00);
        @(negedge clk); check_val("pc_upd_conflict", {16'd0, pc}, 32'h0001); sync();
        repeat (10) @(posedge clk);
        @(negedge clk); check_val("err_sticky", {31'd0, err_conflict}, 32'd1); sync();

        halt = 1'b1; bus_cycle("halt", 1'b0, 8'h00);
        @(negedge clk); check_val("cpu_run_halt", {31'd0, cpu_run}, 32'd0); sync();
        cnt_en = 1'b1;      bus_cycle("halt_inc", 1'b0, 8'h00);
        ram_read_pc = 1'b1; bus_cycle("halt_rd", 1'b0, 8'h00);
        @(negedge clk); check_val("pc_frozen", {16'd0, pc}, 32'h0001); sync();

        pulse_reset();
        load_byte(8'hAA, 1'b0);
        load_byte(8'hBB, 1'b0);
        pulse_reset();
        sync();
        @(negedge clk); check_val("ready_after_rst", {31'd0, ld_ready}, 32'd1); sync();
        load_byte(8'hCC, 1'b1);
        @(negedge clk); check_val("run_reload", {31'd0, cpu_run}, 32'd1); sync();
        ram_read_pc = 1'b1; cnt_en = 1'b1; bus_cycle("reload_mem0", 1'b1, 8'hCC);
        ram_read_pc = 1'b1; cnt_en = 1'b1; bus_cycle("kept_mem1", 1'b1, 8'hBB);
        ram_read_pc = 1'b1;                bus_cycle("kept_mem2", 1'b1, 8'h5A);

        pulse_reset();
        for (int i = 0; i < 1024; i++) begin
            b = 8'(i) ^ 8'hA5;
            load_byte(b, 1'b0);
        end
        @(negedge clk);
        check_val("run_full", {31'd0, cpu_run}, 32'd1);
        check_val("ready_full", {31'd0, ld_ready}, 32'd0);
        sync();
        ram_read_pc = 1'b1; bus_cycle("full_mem0", 1'b1, 8'hA5);
        mreg_h_load = 1'b1; mreg_l_load = 1'b1; bus_in = 8'h03; bus_cycle("mreg_0303", 1'b0, 8'h00);
        mreg_l_load = 1'b1; bus_in = 8'hFF; bus_cycle("mreg_03ff", 1'b0, 8'h00);
        ram_read_mreg = 1'b1; bus_cycle("full_mem3ff", 1'b1, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
